// File: rtl/bist_misr_ctrl_pkg.sv
// Shared BIST types and constants.
// State encoding and default MISR feedback polynomial.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // CRC-16-CCITT taps, x^16 implicit
    localparam logic [15:0] CRC16_CCITT = 16'h1021;

endpackage

// File: rtl/bist_misr_ctrl_if.sv
// Control/response bundle between BIST controller and MISR.
// master = BIST controller side, slave = MISR side.
interface bist_misr_ctrl_if #(
    parameter int SIG_W = 16,
    parameter int IN_W  = 10,
    parameter int CNT_W = 16
) ();

    logic             start;
    logic [CNT_W-1:0] n_cycles;
    logic [SIG_W-1:0] golden;
    logic             data_valid;
    logic [IN_W-1:0]  data_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, n_cycles, golden, data_valid, data_in,
        input  busy, done, pass, signature
    );

    modport slave (
        input  start, n_cycles, golden, data_valid, data_in,
        output busy, done, pass, signature
    );

endinterface

// File: rtl/bist_misr_ctrl_misr_core.sv
// Combinational Galois MISR step.
// Shift left, fold MSB through POLY, xor in the response word.
module misr_core #(
    parameter int               SIG_W = 16,
    parameter int               IN_W  = 10,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021)
) (
    input  logic [SIG_W-1:0] sig_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [SIG_W-1:0] next_o
);

    logic [SIG_W-1:0] data_ext;

    // zero-extend the response word, then one compression step
    always_comb begin
        data_ext              = '0;
        data_ext[IN_W-1:0]    = data_i;
        next_o = {sig_i[SIG_W-2:0], 1'b0}
               ^ (sig_i[SIG_W-1] ? POLY : '0)
               ^ data_ext;
    end

endmodule

// File: rtl/bist_misr_ctrl.sv
// MISR with session FSM, capture counter and golden compare.
// All outputs come straight from registers.
module bist_misr_ctrl
    import bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               IN_W  = 10,
    parameter int               CNT_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(CRC16_CCITT),
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic              clock,
    input  logic              reset,
    bist_misr_ctrl_if.slave   bus
);

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic             pass_q, pass_d;
    logic [SIG_W-1:0] sig_next;

    misr_core #(
        .SIG_W (SIG_W),
        .IN_W  (IN_W),
        .POLY  (POLY)
    ) u_core (
        .sig_i  (sig_q),
        .data_i (bus.data_in),
        .next_o (sig_next)
    );

    // state and datapath registers, reset beats everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            sig_q    <= SEED;
            rem_q    <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            rem_q    <= rem_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

    // next-state: session start, capture steps, final compare
    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        rem_d    = rem_q;
        golden_d = golden_q;
        pass_d   = pass_q;
        unique case (state_q)
            CAPTURE: begin
                if (bus.data_valid) begin
                    sig_d = sig_next;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                        pass_d  = (sig_next == golden_q);
                    end
                end
            end
            IDLE, DONE: begin
                if (bus.start) begin
                    sig_d    = SEED;
                    rem_d    = bus.n_cycles;
                    golden_d = bus.golden;
                    if (bus.n_cycles == '0) begin
                        state_d = DONE;
                        pass_d  = (SEED == bus.golden);
                    end else begin
                        state_d = CAPTURE;
                        pass_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pass_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = (state_q == CAPTURE);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;

endmodule

// File: doc/bist_misr_ctrl.md
# bist_misr_ctrl

Parametrised multiple-input signature register with built-in session control and golden-signature compare. It compresses the per-scan BIST response bus into a SIG_W-bit signature over a programmed number of valid capture cycles, then reports done and pass/fail. It sits at the output of the scan chain and the CUT observation points, next to the pattern generator, and is driven by the BIST controller.

## Interface
- SIG_W, 16: signature width; must satisfy 2 ≤ SIG_W.
- IN_W, 10: response bus width; must satisfy 1 ≤ IN_W ≤ SIG_W.
- POLY, 16'h1021: feedback polynomial taps, bit k set = tap into bit k; x^SIG_W term implicit.
- SEED, 0: signature value loaded at session start.
- CNT_W, 16: width of the capture-cycle counter.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a session when idle or done.
- n_cycles  in  CNT_W  number of valid samples to compress; sampled on accepted start.
- golden  in  SIG_W  expected signature; sampled on accepted start.
- data_valid  in  1  data_in is compressed this cycle when high during CAPTURE.
- data_in  in  IN_W  response bus; data_in[0] feeds signature bit 0.
- busy  out  1  high in CAPTURE.
- done  out  1  high in DONE.
- pass  out  1  final signature equals latched golden; valid only while done.
- signature  out  SIG_W  current signature register.

## Operation
- States: IDLE, CAPTURE, DONE (3-state FSM).
- Compression step: next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extend(data_in). Galois form; no pipelining.
- IDLE: signature holds. start → signature ← SEED, remaining ← n_cycles, golden_q ← golden. If n_cycles == 0, go to DONE with pass ← (SEED == golden). Otherwise go to CAPTURE.
- CAPTURE: data_valid=1 → one compression step and remaining decrements. data_valid=0 → signature and remaining hold. On the step with remaining == 1: go to DONE, pass ← (next == golden_q).
- CAPTURE: start is ignored; no restart mid-session.
- DONE: signature, pass and done hold. start → new session exactly as from IDLE. data_valid is ignored.
- Reset: signature ← SEED, state ← IDLE, busy/done/pass ← 0, remaining ← 0. Reset wins over start and data_valid in the same cycle, including mid-session.
- Counter is unsigned and never wraps; it only decrements from nonzero.

## Timing
- start accepted at edge t: busy=1 from t+1, and the first sample can be compressed at edge t+1.
- Sample presented with data_valid in cycle c: signature reflects it after edge c.
- Last valid sample at edge t: done=1, busy=0, and pass/signature are final from t+1. Total latency is one cycle after the last sample.
- n_cycles == 0: done=1 at start+1, with no busy cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package bist_pkg: state enum (IDLE, CAPTURE, DONE) and the default CRC-16-CCITT polynomial constant.
- One sub-module, misr_core: the combinational next-signature function parameterised by SIG_W, IN_W and POLY. It is reused by a future parallel-channel compactor.
- The top level holds the FSM, counter, golden latch and pass register.

## Test plan
- Default parameters, SEED=0, n_cycles=2, samples 10'h3FF then 10'h000 → signature 16'h03FF, then 16'h07FE; done one cycle after the 2nd sample. golden=16'h07FE gives pass=1; golden=16'h07FF gives pass=0.
- SEED=16'h8000, n_cycles=1, data_in=0 → signature 16'h1021 (feedback from MSB), done=1, busy=0.
- n_cycles=3 with data_valid gaps of 2 idle cycles between samples → signature equals the gap-free run; done only after the 3rd valid sample.
- start pulsed during CAPTURE → ignored, and latched golden/n_cycles are unchanged. start in DONE → fresh session from SEED, done drops next cycle.
- reset asserted mid-CAPTURE together with start and data_valid → next cycle IDLE, signature=SEED, busy/done/pass=0.
- n_cycles=0 with golden=SEED → done=1 and pass=1 at start+1, busy never high.
